// File: rtl/bpred_pkg.sv
// Shared types for the execute-side branch-predictor resolve path:
// per-branch prediction metadata and the update FSM states.
package bpred_pkg;

   localparam int unsigned BIMODAL_W = 12;

   typedef struct packed {
      logic                 p_dir;
      logic [31:0]          p_target;
      logic [31:0]          PC4;
      logic [BIMODAL_W-1:0] bimodal;
      logic                 isCall;
      logic                 isRet;
   } bpred_meta_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_UPD  = 1'b1
   } bpred_state_t;

endpackage

// File: rtl/bpred_meta_fifo.sv
// In-order queue of prediction metadata between fetch and execute.
// Flush empties the queue and drops any same-cycle write.
module bpred_meta_fifo
   import bpred_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        flush,
   input  logic        wr_en,
   input  bpred_meta_t wr_data,
   input  logic        rd_en,
   output bpred_meta_t rd_data,
   output logic        full,
   output logic        empty
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   bpred_meta_t          mem [DEPTH];
   logic [PTR_W-1:0]     wr_ptr;
   logic [PTR_W-1:0]     rd_ptr;
   logic [CNT_W-1:0]     count;

   assign rd_data = mem[rd_ptr];
   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);

   always_ff @(posedge clk) begin
      if (wr_en && !flush) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         // write pointer is left alone; emptiness comes from rd_ptr catching up
         rd_ptr <= wr_ptr;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/bpred_resolve.sv
// Execute-side end of the branch-predictor update interface: pops metadata on
// resolve, detects mispredicts, drives the predictor update bundle and redirect.
module bpred_resolve #(
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned BIMODAL_W = bpred_pkg::BIMODAL_W
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 fetch_bpredres_valid,
   input  logic                 fetch_bpredres_p_dir,
   input  logic [31:0]          fetch_bpredres_p_target,
   input  logic [31:0]          fetch_bpredres_PC4,
   input  logic [BIMODAL_W-1:0] fetch_bpredres_bimodal,
   input  logic                 fetch_bpredres_isCall,
   input  logic                 fetch_bpredres_isRet,
   output logic                 bpredres_fetch_full,
   input  logic                 exec_bpredres_valid,
   input  logic                 exec_bpredres_dir,
   input  logic [31:0]          exec_bpredres_target,
   output logic                 bpredres_exec_ready,
   input  logic                 soin_bpredictor_stall,
   output logic                 execute_bpredictor_update,
   output logic [31:0]          execute_bpredictor_PC4,
   output logic [31:0]          execute_bpredictor_target,
   output logic                 execute_bpredictor_dir,
   output logic                 execute_bpredictor_miss,
   output logic [BIMODAL_W-1:0] execute_bpredictor_bimodal,
   output logic                 execute_missPred,
   output logic                 execute_c_r_after_r,
   output logic                 execute_isCall,
   output logic [31:0]          bpredres_redirect_PC,
   output logic                 bpredres_underflow
);

   import bpred_pkg::*;

   bpred_meta_t  meta_in;
   bpred_meta_t  head;
   logic         full;
   logic         empty;
   logic         deq;
   logic         enq;
   logic         miss_c;
   logic         flush;
   logic         last_was_ret;
   bpred_state_t state_q;
   bpred_state_t state_d;

   always_comb begin
      meta_in          = '0;
      meta_in.p_dir    = fetch_bpredres_p_dir;
      meta_in.p_target = fetch_bpredres_p_target;
      meta_in.PC4      = fetch_bpredres_PC4;
      meta_in.bimodal  = fetch_bpredres_bimodal;
      meta_in.isCall   = fetch_bpredres_isCall;
      meta_in.isRet    = fetch_bpredres_isRet;
   end

   assign bpredres_exec_ready = !((state_q == ST_UPD) && soin_bpredictor_stall);
   assign deq                 = exec_bpredres_valid && bpredres_exec_ready && !empty;
   assign enq                 = fetch_bpredres_valid && (!full || deq);
   assign bpredres_fetch_full = full;

   // a not-taken resolve never compares targets
   assign miss_c = (head.p_dir != exec_bpredres_dir) ||
                   (exec_bpredres_dir && (head.p_target != exec_bpredres_target));
   assign flush  = deq && miss_c;

   bpred_meta_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (flush),
      .wr_en   (enq),
      .wr_data (meta_in),
      .rd_en   (deq),
      .rd_data (head),
      .full    (full),
      .empty   (empty)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (deq) state_d = ST_UPD;
         ST_UPD:  if (!deq && !soin_bpredictor_stall) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign execute_bpredictor_update = (state_q == ST_UPD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         execute_bpredictor_PC4     <= '0;
         execute_bpredictor_target  <= '0;
         execute_bpredictor_dir     <= 1'b0;
         execute_bpredictor_miss    <= 1'b0;
         execute_bpredictor_bimodal <= '0;
         execute_c_r_after_r        <= 1'b0;
         execute_isCall             <= 1'b0;
         bpredres_redirect_PC       <= '0;
         execute_missPred           <= 1'b0;
         last_was_ret               <= 1'b0;
         bpredres_underflow         <= 1'b0;
      end else begin
         execute_missPred <= flush;
         if (deq) begin
            execute_bpredictor_PC4     <= head.PC4;
            execute_bpredictor_target  <= exec_bpredres_target;
            execute_bpredictor_dir     <= exec_bpredres_dir;
            execute_bpredictor_miss    <= miss_c;
            execute_bpredictor_bimodal <= head.bimodal;
            execute_c_r_after_r        <= miss_c && (head.isCall || head.isRet) && last_was_ret;
            execute_isCall             <= head.isCall;
            bpredres_redirect_PC       <= exec_bpredres_dir ? exec_bpredres_target : head.PC4;
         end
         if (flush)    last_was_ret <= 1'b0;
         else if (deq) last_was_ret <= head.isRet;
         if (exec_bpredres_valid && empty) bpredres_underflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_bpred_resolve.sv
// Scoreboard bench for bpred_resolve: a metadata model queue mirrors fetch,
// expected update bundles are queued on resolve and compared on the update cycle.
module tb_bpred_resolve;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned BW    = 12;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          fetch_bpredres_valid;
   logic          fetch_bpredres_p_dir;
   logic [31:0]   fetch_bpredres_p_target;
   logic [31:0]   fetch_bpredres_PC4;
   logic [BW-1:0] fetch_bpredres_bimodal;
   logic          fetch_bpredres_isCall;
   logic          fetch_bpredres_isRet;
   logic          bpredres_fetch_full;
   logic          exec_bpredres_valid;
   logic          exec_bpredres_dir;
   logic [31:0]   exec_bpredres_target;
   logic          bpredres_exec_ready;
   logic          soin_bpredictor_stall;
   logic          execute_bpredictor_update;
   logic [31:0]   execute_bpredictor_PC4;
   logic [31:0]   execute_bpredictor_target;
   logic          execute_bpredictor_dir;
   logic          execute_bpredictor_miss;
   logic [BW-1:0] execute_bpredictor_bimodal;
   logic          execute_missPred;
   logic          execute_c_r_after_r;
   logic          execute_isCall;
   logic [31:0]   bpredres_redirect_PC;
   logic          bpredres_underflow;

   always #5 clk = ~clk;

   bpred_resolve #(
      .DEPTH     (DEPTH),
      .BIMODAL_W (BW)
   ) dut (
      .clk                        (clk),
      .reset_n                    (reset_n),
      .fetch_bpredres_valid       (fetch_bpredres_valid),
      .fetch_bpredres_p_dir       (fetch_bpredres_p_dir),
      .fetch_bpredres_p_target    (fetch_bpredres_p_target),
      .fetch_bpredres_PC4         (fetch_bpredres_PC4),
      .fetch_bpredres_bimodal     (fetch_bpredres_bimodal),
      .fetch_bpredres_isCall      (fetch_bpredres_isCall),
      .fetch_bpredres_isRet       (fetch_bpredres_isRet),
      .bpredres_fetch_full        (bpredres_fetch_full),
      .exec_bpredres_valid        (exec_bpredres_valid),
      .exec_bpredres_dir          (exec_bpredres_dir),
      .exec_bpredres_target       (exec_bpredres_target),
      .bpredres_exec_ready        (bpredres_exec_ready),
      .soin_bpredictor_stall      (soin_bpredictor_stall),
      .execute_bpredictor_update  (execute_bpredictor_update),
      .execute_bpredictor_PC4     (execute_bpredictor_PC4),
      .execute_bpredictor_target  (execute_bpredictor_target),
      .execute_bpredictor_dir     (execute_bpredictor_dir),
      .execute_bpredictor_miss    (execute_bpredictor_miss),
      .execute_bpredictor_bimodal (execute_bpredictor_bimodal),
      .execute_missPred           (execute_missPred),
      .execute_c_r_after_r        (execute_c_r_after_r),
      .execute_isCall             (execute_isCall),
      .bpredres_redirect_PC       (bpredres_redirect_PC),
      .bpredres_underflow         (bpredres_underflow)
   );

   typedef struct {
      logic          pdir;
      logic [31:0]   ptgt;
      logic [31:0]   pc4;
      logic [BW-1:0] bim;
      logic          call;
      logic          ret;
   } meta_t;

   typedef struct {
      logic [31:0]   pc4;
      logic [31:0]   tgt;
      logic [31:0]   redir;
      logic          dir;
      logic          miss;
      logic          call;
      logic          crr;
      logic [BW-1:0] bim;
   } exp_t;

   meta_t mq[$];
   exp_t  sb_q[$];
   exp_t  last_e;
   logic  m_last_ret;
   int    n_vec;
   int    n_err;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_fetch(input logic pdir, input logic [31:0] ptgt, input logic [31:0] pc4,
                              input logic call, input logic ret);
      meta_t m;
      m.pdir = pdir;
      m.ptgt = ptgt;
      m.pc4  = pc4;
      m.bim  = BW'($urandom);
      m.call = call;
      m.ret  = ret;
      fetch_bpredres_valid    = 1'b1;
      fetch_bpredres_p_dir    = m.pdir;
      fetch_bpredres_p_target = m.ptgt;
      fetch_bpredres_PC4      = m.pc4;
      fetch_bpredres_bimodal  = m.bim;
      fetch_bpredres_isCall   = m.call;
      fetch_bpredres_isRet    = m.ret;
      mq.push_back(m);
   endtask

   task automatic enq(input logic pdir, input logic [31:0] ptgt, input logic [31:0] pc4,
                      input logic call, input logic ret);
      drive_fetch(pdir, ptgt, pc4, call, ret);
      step();
      fetch_bpredres_valid = 1'b0;
   endtask

   // pops the model head and queues the bundle the DUT should emit
   task automatic push_exp(input logic dir, input logic [31:0] tgt);
      meta_t m;
      exp_t  e;
      m      = mq.pop_front();
      e.pc4  = m.pc4;
      e.tgt  = tgt;
      e.dir  = dir;
      e.miss = (m.pdir != dir) || (dir && (m.ptgt != tgt));
      e.bim  = m.bim;
      e.call = m.call;
      e.crr  = e.miss && (m.call || m.ret) && m_last_ret;
      e.redir = dir ? tgt : m.pc4;
      m_last_ret = e.miss ? 1'b0 : m.ret;
      if (e.miss) mq.delete();
      sb_q.push_back(e);
   endtask

   task automatic drive_exec(input logic dir, input logic [31:0] tgt);
      exec_bpredres_valid  = 1'b1;
      exec_bpredres_dir    = dir;
      exec_bpredres_target = tgt;
      push_exp(dir, tgt);
   endtask

   task automatic check_upd();
      chk("sb_depth", 64'(sb_q.size()), 64'd1);
      if (sb_q.size() != 0) begin
         last_e = sb_q.pop_front();
         chk("update",   64'(execute_bpredictor_update), 64'd1);
         chk("upd_pc4",  64'(execute_bpredictor_PC4), 64'(last_e.pc4));
         chk("upd_tgt",  64'(execute_bpredictor_target), 64'(last_e.tgt));
         chk("upd_dir",  64'(execute_bpredictor_dir), 64'(last_e.dir));
         chk("upd_miss", 64'(execute_bpredictor_miss), 64'(last_e.miss));
         chk("upd_bim",  64'(execute_bpredictor_bimodal), 64'(last_e.bim));
         chk("missPred", 64'(execute_missPred), 64'(last_e.miss));
         chk("isCall",   64'(execute_isCall), 64'(last_e.call));
         chk("c_r_a_r",  64'(execute_c_r_after_r), 64'(last_e.crr));
         if (last_e.miss) chk("redirect", 64'(bpredres_redirect_PC), 64'(last_e.redir));
      end
   endtask

   task automatic resolve(input logic dir, input logic [31:0] tgt);
      drive_exec(dir, tgt);
      step();
      exec_bpredres_valid = 1'b0;
      check_upd();
   endtask

   task automatic resolve_ok();
      resolve(mq[0].pdir, mq[0].ptgt);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      m_last_ret = 1'b0;
      reset_n = 1'b0;
      fetch_bpredres_valid = 1'b0;
      fetch_bpredres_p_dir = 1'b0;
      fetch_bpredres_p_target = '0;
      fetch_bpredres_PC4 = '0;
      fetch_bpredres_bimodal = '0;
      fetch_bpredres_isCall = 1'b0;
      fetch_bpredres_isRet = 1'b0;
      exec_bpredres_valid = 1'b0;
      exec_bpredres_dir = 1'b0;
      exec_bpredres_target = '0;
      soin_bpredictor_stall = 1'b0;
      step();
      step();
      chk("rst_update",   64'(execute_bpredictor_update), 64'd0);
      chk("rst_full",     64'(bpredres_fetch_full), 64'd0);
      chk("rst_ready",    64'(bpredres_exec_ready), 64'd1);
      chk("rst_missPred", 64'(execute_missPred), 64'd0);
      chk("rst_redirect", 64'(bpredres_redirect_PC), 64'd0);
      chk("rst_underflow",64'(bpredres_underflow), 64'd0);
      reset_n = 1'b1;
      step();

      // correctly predicted taken branch
      enq(1'b1, 32'h100, 32'h44, 1'b0, 1'b0);
      resolve(1'b1, 32'h100);
      step();
      chk("upd_drop", 64'(execute_bpredictor_update), 64'd0);

      // predicted not-taken, actually taken: flush and redirect
      enq(1'b0, 32'h0, 32'h88, 1'b0, 1'b0);
      enq(1'b1, 32'h999, 32'h8c, 1'b0, 1'b0);
      resolve(1'b1, 32'h200);
      chk("flush_count", 64'(dut.u_fifo.count), 64'd0);
      step();
      chk("missPred_1cyc", 64'(execute_missPred), 64'd0);

      // fill, then simultaneous enqueue/dequeue while full, then drain in order
      for (int i = 0; i < 8; i++) begin
         enq(1'b1, 32'h1000 + 32'(i * 16), 32'h500 + 32'(i * 4), 1'b0, 1'b0);
      end
      chk("full", 64'(bpredres_fetch_full), 64'd1);
      drive_exec(mq[0].pdir, mq[0].ptgt);
      drive_fetch(1'b1, 32'h1080, 32'h520, 1'b0, 1'b0);
      step();
      exec_bpredres_valid = 1'b0;
      fetch_bpredres_valid = 1'b0;
      check_upd();
      chk("full_keep",  64'(bpredres_fetch_full), 64'd1);
      chk("count_keep", 64'(dut.u_fifo.count), 64'd8);
      for (int i = 0; i < 8; i++) begin
         resolve_ok();
      end
      step();
      chk("drained_full", 64'(bpredres_fetch_full), 64'd0);

      // predictor stall holds the bundle and blocks execute
      enq(1'b1, 32'h700, 32'h70, 1'b0, 1'b0);
      soin_bpredictor_stall = 1'b1;
      resolve_ok();
      chk("stall_ready", 64'(bpredres_exec_ready), 64'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_update", 64'(execute_bpredictor_update), 64'd1);
         chk("stall_ready",  64'(bpredres_exec_ready), 64'd0);
         chk("stall_pc4",    64'(execute_bpredictor_PC4), 64'(last_e.pc4));
         chk("stall_tgt",    64'(execute_bpredictor_target), 64'(last_e.tgt));
      end
      soin_bpredictor_stall = 1'b0;
      #1;
      chk("unstall_ready", 64'(bpredres_exec_ready), 64'd1);
      step();
      chk("unstall_update", 64'(execute_bpredictor_update), 64'd0);

      // return resolved correctly, then a mispredicted call
      enq(1'b1, 32'h300, 32'h60, 1'b0, 1'b1);
      enq(1'b0, 32'h0, 32'h64, 1'b1, 1'b0);
      resolve(1'b1, 32'h300);
      resolve(1'b1, 32'h400);

      // resolve against an empty queue
      exec_bpredres_valid = 1'b1;
      exec_bpredres_dir = 1'b1;
      exec_bpredres_target = 32'h123;
      step();
      exec_bpredres_valid = 1'b0;
      chk("underflow",    64'(bpredres_underflow), 64'd1);
      chk("uf_no_update", 64'(execute_bpredictor_update), 64'd0);

      // asynchronous reset mid-update with four entries left
      for (int i = 0; i < 5; i++) begin
         enq(1'b1, 32'h2000 + 32'(i * 8), 32'h800 + 32'(i * 4), 1'b0, 1'b0);
      end
      resolve_ok();
      reset_n = 1'b0;
      #1;
      chk("arst_update",    64'(execute_bpredictor_update), 64'd0);
      chk("arst_full",      64'(bpredres_fetch_full), 64'd0);
      chk("arst_count",     64'(dut.u_fifo.count), 64'd0);
      chk("arst_underflow", 64'(bpredres_underflow), 64'd0);
      chk("arst_pc4",       64'(execute_bpredictor_PC4), 64'd0);
      chk("arst_missPred",  64'(execute_missPred), 64'd0);
      mq.delete();
      sb_q.delete();
      m_last_ret = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      // queue usable again after reset
      enq(1'b1, 32'h3000, 32'h900, 1'b0, 1'b0);
      resolve(1'b0, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
